// File: rtl/anna_phase_pkg.sv
// -----------------------------------------------------------------------------
// anna_phase_pkg
//   Shared definitions for the phase sequencer receive side.
//   - phase_state_t : lock state machine encoding (UNLOCKED / SYNCING / LOCKED)
//   - ERR_CNT_W     : width of the saturating mismatch counter output
//   - ERR_CNT_MAX   : saturation ceiling of that counter
// -----------------------------------------------------------------------------
package anna_phase_pkg;

   typedef enum logic [1:0] {
      PH_UNLOCKED = 2'd0,
      PH_SYNCING  = 2'd1,
      PH_LOCKED   = 2'd2
   } phase_state_t;

   localparam int                    ERR_CNT_W   = 8;
   localparam logic [ERR_CNT_W-1:0]  ERR_CNT_MAX = '1;

endpackage

// File: rtl/phase_seq_check.sv
// -----------------------------------------------------------------------------
// phase_seq_check
//   Combinational sequence checker. Computes the phase index that should follow
//   the previously sampled one and reports whether the current sample matches.
//   A registered source reset forces the expectation to phase 0. Wrap-around is
//   modulo STATE_COUNT, so non-power-of-two rotations wrap at STATE_COUNT-1.
//   Samples outside 0..STATE_COUNT-1 never match.
//
// Ports
//   prev_state  in   STATE_BITS  phase index sampled on the previous cycle
//   src_rst     in   1           counter reset seen on the previous cycle
//   state_in    in   STATE_BITS  phase index sampled this cycle
//   match       out  1           state_in is the legal successor
// -----------------------------------------------------------------------------
module phase_seq_check #(
   parameter int STATE_COUNT = 4,
   parameter int STATE_BITS  = $clog2(STATE_COUNT)
) (
   input  logic [STATE_BITS-1:0] prev_state,
   input  logic                  src_rst,
   input  logic [STATE_BITS-1:0] state_in,
   output logic                  match
);

   localparam logic [STATE_BITS:0] COUNT_W = (STATE_BITS+1)'(STATE_COUNT);

   logic [STATE_BITS:0]   incr;
   logic [STATE_BITS-1:0] expected;

   always_comb begin
      incr = {1'b0, prev_state} + (STATE_BITS+1)'(1);
      // One conditional subtract is enough: prev_state+1 <= 2**STATE_BITS,
      // which is always below 2*STATE_COUNT.
      if (incr >= COUNT_W) begin
         incr = incr - COUNT_W;
      end
      expected = src_rst ? '0 : incr[STATE_BITS-1:0];
      match    = (state_in == expected) && ({1'b0, state_in} < COUNT_W);
   end

endmodule

// File: rtl/phase_tracker.sv
// -----------------------------------------------------------------------------
// phase_tracker
//   Receive side of the CPU phase sequencer. Samples the rolling phase index,
//   verifies the sequence 0,1,..,STATE_COUNT-1,0 and, once LOCK_CYCLES
//   consecutive correct steps have been seen, drives registered one-hot phase
//   enables. Every out-of-sequence step while locked drops lock and pulses
//   seq_err.
//
// Configuration macro
//   PHASE_ERR_COUNT_EN : when defined, err_count is a saturating (255) count of
//                        seq_err pulses, cleared only by reset. When undefined,
//                        err_count is tied to 0 and no counter exists.
//
// Ports
//   clk           in   1             clock, all logic on posedge
//   reset         in   1             synchronous, active-high
//   state_in      in   STATE_BITS    phase index from the counter
//   src_reset     in   1             counter's own reset (same cycle as counter)
//   phase_onehot  out  STATE_COUNT   bit k high => phase k active (locked only)
//   locked        out  1             sequence verified
//   seq_err       out  1             1-cycle pulse on mismatch while locked
//   rotation      out  1             1-cycle pulse: locked and last phase
//   err_count     out  8             saturating mismatch count
// -----------------------------------------------------------------------------
module phase_tracker
   import anna_phase_pkg::*;
#(
   parameter int STATE_COUNT = 4,
   parameter int STATE_BITS  = $clog2(STATE_COUNT),
   parameter int LOCK_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [STATE_BITS-1:0]  state_in,
   input  logic                   src_reset,
   output logic [STATE_COUNT-1:0] phase_onehot,
   output logic                   locked,
   output logic                   seq_err,
   output logic                   rotation,
   output logic [ERR_CNT_W-1:0]   err_count
);

   localparam int                    CNT_W       = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0]      LOCK_TARGET = CNT_W'(LOCK_CYCLES);
   localparam logic [STATE_BITS-1:0] LAST_PHASE  = STATE_BITS'(STATE_COUNT - 1);

   phase_state_t           state_q;
   phase_state_t           state_nxt;
   logic [STATE_BITS-1:0]  prev_q;
   logic                   src_rst_q;
   logic [CNT_W-1:0]       match_cnt;
   logic [CNT_W-1:0]       match_cnt_nxt;
   logic                   match;
   logic                   err_nxt;
   logic                   lock_nxt;
   logic [STATE_COUNT-1:0] onehot_nxt;

   phase_seq_check #(
      .STATE_COUNT (STATE_COUNT),
      .STATE_BITS  (STATE_BITS)
   ) u_seq_check (
      .prev_state (prev_q),
      .src_rst    (src_rst_q),
      .state_in   (state_in),
      .match      (match)
   );

   // Next-state decision. Outputs are decoded from the next state so that the
   // sample that completes the lock is already presented on the locking edge.
   always_comb begin
      state_nxt     = state_q;
      match_cnt_nxt = match_cnt;
      err_nxt       = 1'b0;
      unique case (state_q)
         PH_UNLOCKED: begin
            // First sample after reset only seeds prev_q; nothing to compare.
            state_nxt     = PH_SYNCING;
            match_cnt_nxt = '0;
         end
         PH_SYNCING: begin
            if (match) begin
               if (match_cnt + CNT_W'(1) == LOCK_TARGET) begin
                  state_nxt     = PH_LOCKED;
                  match_cnt_nxt = '0;
               end else begin
                  match_cnt_nxt = match_cnt + CNT_W'(1);
               end
            end else begin
               match_cnt_nxt = '0;
            end
         end
         PH_LOCKED: begin
            if (!match) begin
               state_nxt     = PH_SYNCING;
               match_cnt_nxt = '0;
               err_nxt       = 1'b1;
            end
         end
         default: begin
            state_nxt     = PH_UNLOCKED;
            match_cnt_nxt = '0;
         end
      endcase

      lock_nxt = (state_nxt == PH_LOCKED);
      for (int k = 0; k < STATE_COUNT; k++) begin
         onehot_nxt[k] = lock_nxt && (state_in == STATE_BITS'(k));
      end
   end

   // Registered FSM, sample history and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= PH_UNLOCKED;
         prev_q       <= '0;
         src_rst_q    <= 1'b0;
         match_cnt    <= '0;
         phase_onehot <= '0;
         locked       <= 1'b0;
         seq_err      <= 1'b0;
         rotation     <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         prev_q       <= state_in;
         src_rst_q    <= src_reset;
         match_cnt    <= match_cnt_nxt;
         phase_onehot <= onehot_nxt;
         locked       <= lock_nxt;
         seq_err      <= err_nxt;
         rotation     <= lock_nxt && (state_in == LAST_PHASE);
      end
   end

`ifdef PHASE_ERR_COUNT_EN
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
   endfunction

   logic [ERR_CNT_W-1:0] err_cnt_q;

   // Counts on the same edge that raises seq_err, so the count already
   // includes the pulse being presented.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (err_nxt) begin
         err_cnt_q <= sat_inc(err_cnt_q);
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule
